// File: rtl/see_inject_campaign_pkg.sv
// rtl/see_inject_campaign_pkg.sv - shared types, defaults and width helper for the SEE campaign
package see_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_RESULT,
    ST_FIN
  } see_state_e;

  localparam logic [15:0] DEFAULT_POLY = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Index width for a counter over n items; never below 1 so n=1 still gets a register.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/see_inject_campaign_lfsr.sv
// rtl/see_inject_campaign_lfsr.sv - Galois LFSR stimulus source with load and step controls
module see_lfsr
  import see_pkg::*;
#(
  parameter int unsigned       W     = 16,
  parameter int unsigned       OUT_W = 9,
  parameter logic [W-1:0]      POLY  = W'(DEFAULT_POLY),
  parameter logic [W-1:0]      SEED  = W'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  output logic [OUT_W-1:0] state_o
);

  logic [W-1:0] state_q, state_d;

  // Load wins over step; a step shifts right and folds the taps in when the LSB falls out set.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = SEED;
    end else if (step_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? POLY : '0);
    end
  end

  // State register, seeded at reset so the first campaign needs no explicit load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/see_inject_campaign.sv
// rtl/see_inject_campaign.sv - per-site upset campaign: stimulus, compare, count, report
module see_inject_campaign
  import see_pkg::*;
#(
  parameter int unsigned         N_IN    = 9,
  parameter int unsigned         N_OUT   = 5,
  parameter int unsigned         N_SITES = 49,
  parameter int unsigned         N_VEC   = 256,
  parameter int unsigned         SETTLE  = 2,
  parameter int unsigned         LFSR_W  = 16,
  parameter logic [LFSR_W-1:0]   POLY    = LFSR_W'(DEFAULT_POLY),
  parameter logic [LFSR_W-1:0]   SEED    = LFSR_W'(DEFAULT_SEED),
  parameter int unsigned         CNT_W   = 16,
  localparam int unsigned        SITE_W  = idx_w(N_SITES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   stim_o,
  output logic              inj_en_o,
  output logic [SITE_W-1:0] inj_site_o,
  input  logic [N_OUT-1:0]  gold_i,
  input  logic [N_OUT-1:0]  fault_i,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SITE_W-1:0] res_site,
  output logic [CNT_W-1:0]  res_err_cnt,
  output logic [N_OUT-1:0]  res_out_mask
);

  localparam int unsigned VEC_W = idx_w(N_VEC);
  localparam int unsigned SET_W = idx_w(SETTLE);

  see_state_e         state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [SITE_W-1:0]  site_q, site_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [N_OUT-1:0]   mask_q, mask_d;
  logic [N_IN-1:0]    stim_q, stim_d;
  logic               inj_en_q, busy_q, done_q, res_valid_q;
  logic               lfsr_load, lfsr_step;
  logic [N_IN-1:0]    lfsr_bits;
  logic [N_OUT-1:0]   diff;

  see_lfsr #(
    .W     (LFSR_W),
    .OUT_W (N_IN),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .state_o (lfsr_bits)
  );

  assign diff = gold_i ^ fault_i;

  // Campaign sequencing: reseed per site, one vector per APPLY/SETTLE/SAMPLE pass, then report.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    site_d    = site_q;
    err_d     = err_q;
    mask_d    = mask_q;
    stim_d    = stim_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          site_d  = '0;
          state_d = ST_SEED;
        end
      end
      ST_SEED: begin
        lfsr_load = 1'b1;
        vec_d     = '0;
        err_d     = '0;
        mask_d    = '0;
        state_d   = ST_APPLY;
      end
      ST_APPLY: begin
        stim_d    = lfsr_bits;
        lfsr_step = 1'b1;
        settle_d  = '0;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE - 1)) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        if ((diff != '0) && (err_q != '1)) begin
          err_d = err_q + 1'b1;
        end
        mask_d = mask_q | diff;
        if (vec_q == VEC_W'(N_VEC - 1)) begin
          state_d = ST_RESULT;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = ST_APPLY;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          if (site_q == SITE_W'(N_SITES - 1)) begin
            state_d = ST_FIN;
          end else begin
            site_d  = site_q + 1'b1;
            state_d = ST_SEED;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Abort overrides everything, including a result handshake landing on the same edge.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      site_d  = site_q;
    end
  end

  // State, counters and registered outputs; status flags are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      settle_q    <= '0;
      site_q      <= '0;
      err_q       <= '0;
      mask_q      <= '0;
      stim_q      <= '0;
      inj_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      site_q      <= site_d;
      err_q       <= err_d;
      mask_q      <= mask_d;
      stim_q      <= stim_d;
      inj_en_q    <= (state_d inside {ST_SEED, ST_APPLY, ST_SETTLE, ST_SAMPLE, ST_RESULT});
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_FIN);
      res_valid_q <= (state_d == ST_RESULT);
    end
  end

  assign stim_o       = stim_q;
  assign inj_en_o     = inj_en_q;
  assign inj_site_o   = site_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign res_valid    = res_valid_q;
  assign res_site     = site_q;
  assign res_err_cnt  = err_q;
  assign res_out_mask = mask_q;

endmodule

// File: tb/tb_see_inject_campaign.sv
// tb/tb_see_inject_campaign.sv - directed self-checking bench for see_inject_campaign
module tb_see_inject_campaign;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Instance A: three sites, four vectors, settle of two cycles.
  logic        start_a, abort_a, res_ready_a;
  logic [8:0]  stim_a;
  logic        inj_en_a, busy_a, done_a, res_valid_a;
  logic [1:0]  inj_site_a, res_site_a;
  logic [4:0]  gold_a, fault_a, res_out_mask_a, inj_diff_a;
  logic [15:0] res_err_cnt_a;
  logic [1:0]  mode;

  // Instance B: one site, eight vectors, two-bit counter, always-mismatching faulty copy.
  logic        start_b, abort_b, res_ready_b;
  logic [8:0]  stim_b;
  logic        inj_en_b, busy_b, done_b, res_valid_b;
  logic [0:0]  inj_site_b, res_site_b;
  logic [4:0]  gold_b, fault_b, res_out_mask_b;
  logic [1:0]  res_err_cnt_b;

  see_inject_campaign #(.N_SITES(3), .N_VEC(4), .SETTLE(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .stim_o(stim_a), .inj_en_o(inj_en_a), .inj_site_o(inj_site_a),
    .gold_i(gold_a), .fault_i(fault_a), .busy(busy_a), .done(done_a),
    .res_valid(res_valid_a), .res_ready(res_ready_a), .res_site(res_site_a),
    .res_err_cnt(res_err_cnt_a), .res_out_mask(res_out_mask_a)
  );

  see_inject_campaign #(.N_SITES(1), .N_VEC(8), .SETTLE(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .stim_o(stim_b), .inj_en_o(inj_en_b), .inj_site_o(inj_site_b),
    .gold_i(gold_b), .fault_i(fault_b), .busy(busy_b), .done(done_b),
    .res_valid(res_valid_b), .res_ready(res_ready_b), .res_site(res_site_b),
    .res_err_cnt(res_err_cnt_b), .res_out_mask(res_out_mask_b)
  );

  // Netlist stand-ins: mode 1 upsets bit 2 on site 1; mode 2 adds a stimulus-dependent upset on site 2.
  always_comb begin
    inj_diff_a = 5'b00000;
    if (inj_en_a && (mode != 2'd0) && (inj_site_a == 2'd1)) inj_diff_a = 5'b00100;
    if (inj_en_a && (mode == 2'd2) && (inj_site_a == 2'd2)) inj_diff_a = {stim_a[0], 3'b000, stim_a[3]};
  end
  assign gold_a  = stim_a[4:0] ^ stim_a[8:4];
  assign fault_a = gold_a ^ inj_diff_a;
  assign gold_b  = stim_b[4:0];
  assign fault_b = gold_b ^ (inj_en_b ? 5'b00011 : 5'b00000);

  int          cyc, n_res, n_done, res_cyc0, done_cyc, held;
  logic [8:0]  stim_seq [4];
  logic [8:0]  stim_s1;
  logic [1:0]  got_site [4];
  logic [15:0] got_err [4];
  logic [4:0]  got_mask [4];
  logic [24:0] hold_snap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 0;
  endtask

  // Runs one full campaign on A; optionally withholds res_ready for hold_len cycles at hold_site.
  task automatic run_campaign(input int hold_site, input int hold_len);
    n_res = 0; n_done = 0; res_cyc0 = -1; done_cyc = -1; held = 0;
    res_ready_a = 1'b1;
    pulse_start_a();
    for (int c = 0; c < 100; c++) begin
      cyc = c;
      if (c == 2 || c == 6 || c == 10 || c == 14) stim_seq[c/4] = stim_a;
      if (c == 20) stim_s1 = stim_a;
      if (done_a) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (res_valid_a) begin
        if (res_cyc0 < 0) res_cyc0 = c;
        if ((int'(res_site_a) == hold_site) && (held < hold_len)) begin
          if (held == 0) begin
            hold_snap = {inj_site_a, res_site_a, res_err_cnt_a, res_out_mask_a};
          end else begin
            n_cmp++;
            if ({inj_site_a, res_site_a, res_err_cnt_a, res_out_mask_a} !== hold_snap) begin
              n_fail++;
              $display("FAIL hold_stable cyc=%0d: got %h want %h", c,
                       {inj_site_a, res_site_a, res_err_cnt_a, res_out_mask_a}, hold_snap);
            end
          end
          res_ready_a = 1'b0;
          held++;
        end else begin
          res_ready_a = 1'b1;
          if (n_res < 4) begin
            got_site[n_res] = res_site_a;
            got_err[n_res]  = res_err_cnt_a;
            got_mask[n_res] = res_out_mask_a;
          end
          n_res++;
        end
      end
      tick();
    end
    res_ready_a = 1'b1;
  endtask

  task automatic check_results(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [4:0] m0, input logic [4:0] m1,
                               input logic [4:0] m2);
    logic [15:0] ee [3];
    logic [4:0]  em [3];
    ee[0] = e0; ee[1] = e1; ee[2] = e2;
    em[0] = m0; em[1] = m1; em[2] = m2;
    n_cmp++;
    if (n_res !== 3) begin n_fail++; $display("FAIL %s n_res: got %0d want 3", tag, n_res); end
    n_cmp++;
    if (n_done !== 1) begin n_fail++; $display("FAIL %s n_done: got %0d want 1", tag, n_done); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({got_site[i], got_err[i], got_mask[i]} !== {2'(i), ee[i], em[i]}) begin
        n_fail++;
        $display("FAIL %s result%0d: got site=%0d err=%0d mask=%b want site=%0d err=%0d mask=%b",
                 tag, i, got_site[i], got_err[i], got_mask[i], i, ee[i], em[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({stim_a, inj_en_a, inj_site_a, busy_a, done_a, res_valid_a, res_site_a, res_err_cnt_a, res_out_mask_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got stim=%h en=%b site=%0d busy=%b done=%b valid=%b err=%0d mask=%b want all zero",
               stim_a, inj_en_a, inj_site_a, busy_a, done_a, res_valid_a, res_err_cnt_a, res_out_mask_a);
    end
    n_cmp++;
    if ({stim_b, inj_en_b, busy_b, done_b, res_valid_b, res_err_cnt_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got stim=%h en=%b busy=%b valid=%b want all zero", stim_b, inj_en_b, busy_b, res_valid_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean();
    mode = 2'd0;
    run_campaign(-1, 0);
    check_results("clean", 16'd0, 16'd0, 16'd0, 5'b0, 5'b0, 5'b0);
    n_cmp++;
    if (res_cyc0 !== 17) begin n_fail++; $display("FAIL clean first_result_cyc: got %0d want 17", res_cyc0); end
    n_cmp++;
    if (done_cyc !== 54) begin n_fail++; $display("FAIL clean done_cyc: got %0d want 54", done_cyc); end
    n_cmp++;
    if ({stim_seq[0], stim_seq[1], stim_seq[2], stim_seq[3]} !== {9'h0E1, 9'h070, 9'h138, 9'h09C}) begin
      n_fail++;
      $display("FAIL clean stim_seq: got %h %h %h %h want 0e1 070 138 09c",
               stim_seq[0], stim_seq[1], stim_seq[2], stim_seq[3]);
    end
    n_cmp++;
    if (stim_s1 !== 9'h0E1) begin n_fail++; $display("FAIL clean site1_reseed: got %h want 0e1", stim_s1); end
    n_cmp++;
    if ({busy_a, inj_en_a} !== 2'b00) begin n_fail++; $display("FAIL clean idle_after: got busy=%b en=%b want 0 0", busy_a, inj_en_a); end
  endtask

  task automatic test_site_fault();
    mode = 2'd1;
    run_campaign(-1, 0);
    check_results("site1", 16'd0, 16'd4, 16'd0, 5'b0, 5'b00100, 5'b0);
  endtask

  task automatic test_pattern();
    mode = 2'd2;
    run_campaign(-1, 0);
    check_results("pattern", 16'd0, 16'd4, 16'd3, 5'b0, 5'b00100, 5'b10001);
  endtask

  task automatic test_backpressure();
    mode = 2'd1;
    run_campaign(1, 10);
    n_cmp++;
    if (held !== 10) begin n_fail++; $display("FAIL bp held: got %0d want 10", held); end
    n_cmp++;
    if (done_cyc !== 64) begin n_fail++; $display("FAIL bp done_cyc: got %0d want 64", done_cyc); end
    check_results("bp", 16'd0, 16'd4, 16'd0, 5'b0, 5'b00100, 5'b0);
  endtask

  task automatic test_abort();
    int dn;
    mode = 2'd1;
    res_ready_a = 1'b1;
    pulse_start_a();
    repeat (20) tick();
    n_cmp++;
    if ({busy_a, inj_site_a} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL abort pre: got busy=%b site=%0d want 1 1", busy_a, inj_site_a);
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    n_cmp++;
    if ({busy_a, res_valid_a, inj_en_a} !== 3'b000) begin
      n_fail++; $display("FAIL abort idle: got busy=%b valid=%b en=%b want 0 0 0", busy_a, res_valid_a, inj_en_a);
    end
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done_a) dn++;
      tick();
    end
    n_cmp++;
    if (dn !== 0) begin n_fail++; $display("FAIL abort no_done: got %0d pulses want 0", dn); end
    run_campaign(-1, 0);
    check_results("restart", 16'd0, 16'd4, 16'd0, 5'b0, 5'b00100, 5'b0);
    n_cmp++;
    if ({res_cyc0, stim_seq[0]} !== {32'sd17, 9'h0E1}) begin
      n_fail++; $display("FAIL restart timing: got cyc=%0d stim=%h want 17 0e1", res_cyc0, stim_seq[0]);
    end
    // Abort coinciding with an accepted result must still win.
    pulse_start_a();
    repeat (17) tick();
    n_cmp++;
    if (res_valid_a !== 1'b1) begin n_fail++; $display("FAIL prio valid: got %b want 1", res_valid_a); end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    n_cmp++;
    if ({busy_a, res_valid_a, inj_en_a} !== 3'b000) begin
      n_fail++; $display("FAIL prio abort: got busy=%b valid=%b en=%b want 0 0 0", busy_a, res_valid_a, inj_en_a);
    end
  endtask

  task automatic test_async_reset();
    mode = 2'd1;
    pulse_start_a();
    repeat (10) tick();
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({stim_a, inj_en_a, inj_site_a, busy_a, done_a, res_valid_a, res_site_a, res_err_cnt_a, res_out_mask_a} !== '0) begin
      n_fail++;
      $display("FAIL async_rst: got stim=%h en=%b busy=%b valid=%b err=%0d mask=%b want all zero",
               stim_a, inj_en_a, busy_a, res_valid_a, res_err_cnt_a, res_out_mask_a);
    end
    #2 rst = 1'b0;
    tick();
    run_campaign(-1, 0);
    n_cmp++;
    if ({res_cyc0, done_cyc, stim_seq[0]} !== {32'sd17, 32'sd54, 9'h0E1}) begin
      n_fail++; $display("FAIL async_rst restart: got cyc=%0d done=%0d stim=%h want 17 54 0e1", res_cyc0, done_cyc, stim_seq[0]);
    end
  endtask

  task automatic test_saturation();
    int rc, dc, dn;
    logic [1:0] e;
    logic [4:0] m;
    logic [0:0] s;
    rc = -1; dc = -1; dn = 0; e = '0; m = '0; s = '1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (res_valid_b && rc < 0) begin rc = c; e = res_err_cnt_b; m = res_out_mask_b; s = res_site_b; end
      if (done_b) begin dn++; if (dc < 0) dc = c; end
      tick();
    end
    n_cmp++;
    if (e !== 2'd3) begin n_fail++; $display("FAIL sat err_cnt: got %0d want 3", e); end
    n_cmp++;
    if ({s, m} !== {1'b0, 5'b00011}) begin n_fail++; $display("FAIL sat payload: got site=%0d mask=%b want 0 00011", s, m); end
    n_cmp++;
    if ({rc, dc, dn} !== {32'sd25, 32'sd26, 32'sd1}) begin
      n_fail++; $display("FAIL sat timing: got res=%0d done=%0d pulses=%0d want 25 26 1", rc, dc, dn);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; res_ready_a = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; res_ready_b = 1'b1;
    mode = 2'd0;
    test_reset();
    test_clean();
    test_site_fault();
    test_pattern();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
